// File: rtl/fifo16_share_ctrl.sv
// Shared-write controller for one synchronous 36-bit FIFO16: reset sequencing, round-robin writers, single reader, sticky errors.
// Optional build macro FIFO16_SHARE_PRIO0_EN gives requester 0 strict priority over the round-robin group.
module fifo16_share_ctrl #(
  parameter int NREQ     = 4,
  parameter int RST_HOLD = 5,
  parameter int RST_WAIT = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               SOFT_RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*32-1:0] REQ_DI,
  input  logic [NREQ*4-1:0]  REQ_DIP,
  output logic [NREQ-1:0]    GNT,
  input  logic               RD_REQ,
  output logic               RD_VALID,
  output logic               READY,
  output logic [1:0]         ERR,
  input  logic               CLR_ERR,
  output logic               FIFO_RST,
  output logic               FIFO_WREN,
  output logic [31:0]        FIFO_DI,
  output logic [3:0]         FIFO_DIP,
  output logic               FIFO_RDEN,
  input  logic               FIFO_FULL,
  input  logic               FIFO_ALMOSTFULL,
  input  logic               FIFO_EMPTY,
  input  logic               FIFO_WRERR,
  input  logic               FIFO_RDERR
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (RST_HOLD > RST_WAIT) ? RST_HOLD : RST_WAIT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wren_q;
  logic [31:0]     di_q;
  logic [3:0]      dip_q;
  logic            rdv_q;
  logic [1:0]      err_q, err_d;

  logic            run;
  logic            gate;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   idx;
  logic [31:0]     di_arr  [NREQ];
  logic [3:0]      dip_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign di_arr[g]  = REQ_DI[g*32 +: 32];
    assign dip_arr[g] = REQ_DIP[g*4 +: 4];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == CW'(RST_HOLD - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (cnt_q == CW'(RST_WAIT - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RUN:   state_d = S_RUN;
      default: state_d = S_HOLD;
    endcase
    if (SOFT_RST) begin
      state_d = S_HOLD;
      cnt_d   = '0;
    end
  end

  assign run = (state_q == S_RUN);

  // Near full, a write captured last cycle closes the gate so writes alternate.
  assign gate = ~FIFO_FULL & (~FIFO_ALMOSTFULL | ~wren_q);
  assign elig = REQ & {NREQ{gate & run & ~SOFT_RST}};

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = '0;
    ptr_d = ptr_q;
    GNT   = '0;
`ifdef FIFO16_SHARE_PRIO0_EN
    if (elig[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = PW'((int'(ptr_q) + k) % NREQ);
        if (!found && (idx != '0) && elig[idx]) begin
          found = 1'b1;
          gidx  = idx;
        end
      end
      if (found) ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found) ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
`endif
    if (found) GNT[gidx] = 1'b1;
  end

  always_comb begin
    err_d = (CLR_ERR ? 2'b00 : err_q) | {FIFO_RDERR, FIFO_WRERR};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_HOLD;
      cnt_q   <= '0;
      ptr_q   <= '0;
      wren_q  <= 1'b0;
      di_q    <= '0;
      dip_q   <= '0;
      rdv_q   <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wren_q  <= found;
      rdv_q   <= FIFO_RDEN;
      err_q   <= err_d;
      if (found) begin
        di_q  <= di_arr[gidx];
        dip_q <= dip_arr[gidx];
      end
    end
  end

  // A soft reset kills the pending write and any read in the same cycle.
  assign FIFO_WREN = wren_q & ~SOFT_RST;
  assign FIFO_RDEN = run & RD_REQ & ~FIFO_EMPTY & ~SOFT_RST;
  assign FIFO_DI   = di_q;
  assign FIFO_DIP  = dip_q;
  assign FIFO_RST  = (state_q == S_HOLD);
  assign READY     = run;
  assign RD_VALID  = rdv_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_fifo16_share_ctrl.sv
// Randomized bench for fifo16_share_ctrl against a cycle-level behavioural model of the controller.
module tb_fifo16_share_ctrl;

  localparam int NREQ     = 4;
  localparam int RST_HOLD = 5;
  localparam int RST_WAIT = 4;
  localparam int RUN_AGE  = RST_HOLD + RST_WAIT;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               SOFT_RST = 1'b0;
  logic [NREQ-1:0]    REQ;
  logic [NREQ*32-1:0] REQ_DI;
  logic [NREQ*4-1:0]  REQ_DIP;
  logic [NREQ-1:0]    GNT;
  logic               RD_REQ = 1'b0;
  logic               RD_VALID, READY;
  logic [1:0]         ERR;
  logic               CLR_ERR = 1'b0;
  logic               FIFO_RST, FIFO_WREN, FIFO_RDEN;
  logic [31:0]        FIFO_DI;
  logic [3:0]         FIFO_DIP;
  logic               FIFO_FULL = 1'b0, FIFO_ALMOSTFULL = 1'b0, FIFO_EMPTY = 1'b1;
  logic               FIFO_WRERR = 1'b0, FIFO_RDERR = 1'b0;

  // requester side: pending flag and the word each requester is presenting
  logic        rq   [NREQ];
  logic [31:0] word [NREQ];
  logic [3:0]  par  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_drv
    assign REQ[g]             = rq[g];
    assign REQ_DI[g*32 +: 32] = word[g];
    assign REQ_DIP[g*4 +: 4]  = par[g];
  end

  fifo16_share_ctrl #(.NREQ(NREQ), .RST_HOLD(RST_HOLD), .RST_WAIT(RST_WAIT)) dut (
    .CLK(CLK), .RST_N(RST_N), .SOFT_RST(SOFT_RST),
    .REQ(REQ), .REQ_DI(REQ_DI), .REQ_DIP(REQ_DIP), .GNT(GNT),
    .RD_REQ(RD_REQ), .RD_VALID(RD_VALID), .READY(READY), .ERR(ERR), .CLR_ERR(CLR_ERR),
    .FIFO_RST(FIFO_RST), .FIFO_WREN(FIFO_WREN), .FIFO_DI(FIFO_DI), .FIFO_DIP(FIFO_DIP),
    .FIFO_RDEN(FIFO_RDEN), .FIFO_FULL(FIFO_FULL), .FIFO_ALMOSTFULL(FIFO_ALMOSTFULL),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_WRERR(FIFO_WRERR), .FIFO_RDERR(FIFO_RDERR)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state
  int          age;      // cycles since the last reset/soft-reset entry
  int          ptr;
  bit          m_pend;   // a word was granted last cycle
  logic [31:0] m_di;
  logic [3:0]  m_dip;
  bit          m_rdv;
  logic [1:0]  m_err;

  function automatic int model_grant();
`ifdef FIFO16_SHARE_PRIO0_EN
    if (rq[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      int i = (ptr + k) % NREQ;
      if (i != 0 && rq[i]) return i;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      int i = (ptr + k) % NREQ;
      if (rq[i]) return i;
    end
`endif
    return -1;
  endfunction

  function automatic bit new_req(input int mode, input int i);
    if (mode == 0) return 1'b1;
    if (mode == 2) return (i == 2);
    return ($urandom % 2) == 1;
  endfunction

  task automatic model_reset();
    age = 0; ptr = 0; m_pend = 0; m_di = '0; m_dip = '0; m_rdv = 0; m_err = 2'b00;
  endtask

  // Asserts RST_N asynchronously with busy inputs and checks the immediate reset values.
  task automatic async_reset();
    RD_REQ = 1'b1; FIFO_EMPTY = 1'b0; FIFO_FULL = 1'b0; FIFO_ALMOSTFULL = 1'b0;
    SOFT_RST = 1'b0; CLR_ERR = 1'b0; FIFO_WRERR = 1'b0; FIFO_RDERR = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    check_val("rst_fifo_rst", 64'(FIFO_RST), 64'(1));
    check_val("rst_gnt",      64'(GNT),      64'(0));
    check_val("rst_wren",     64'(FIFO_WREN), 64'(0));
    check_val("rst_rden",     64'(FIFO_RDEN), 64'(0));
    check_val("rst_rd_valid", 64'(RD_VALID), 64'(0));
    check_val("rst_ready",    64'(READY),    64'(0));
    check_val("rst_err",      64'(ERR),      64'(0));
    check_val("rst_di",       64'({FIFO_DIP, FIFO_DI}), 64'(0));
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    model_reset();
  endtask

  task automatic run_cycles(input int mode, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      bit               run, gate, exp_rden;
      int               g;
      logic [NREQ-1:0]  exp_gnt;
      FIFO_FULL       = (mode == 0) ? 1'b0 : (mode == 2) ? (($urandom % 5) == 0) : (($urandom % 6) == 0);
      FIFO_ALMOSTFULL = (mode == 0) ? 1'b0 : (mode == 2) ? 1'b1 : (($urandom % 2) == 0);
      if (FIFO_FULL) FIFO_ALMOSTFULL = 1'b1;
      RD_REQ     = (mode == 3) ? 1'b1 : (($urandom % 2) == 0);
      FIFO_EMPTY = (mode == 3) ? (($urandom % 3) == 0) : (($urandom % 2) == 0);
      FIFO_WRERR = ($urandom % 16) == 0;
      FIFO_RDERR = ($urandom % 16) == 0;
      CLR_ERR    = ($urandom % 10) == 0;
      if (mode == 4) SOFT_RST = (m_pend && ($urandom % 3) == 0) || (($urandom % 64) == 0);
      else           SOFT_RST = ($urandom % 300) == 0;

      @(negedge CLK);
      run      = (age >= RUN_AGE);
      gate     = !FIFO_FULL && (!FIFO_ALMOSTFULL || !m_pend);
      g        = (run && !SOFT_RST && gate) ? model_grant() : -1;
      exp_gnt  = (g >= 0) ? (NREQ'(1) << g) : '0;
      exp_rden = run && RD_REQ && !FIFO_EMPTY && !SOFT_RST;
      check_val("fifo_rst", 64'(FIFO_RST),  64'(age < RST_HOLD));
      check_val("ready",    64'(READY),     64'(run));
      check_val("gnt",      64'(GNT),       64'(exp_gnt));
      check_val("wren",     64'(FIFO_WREN), 64'(m_pend && !SOFT_RST));
      check_val("di",       64'({FIFO_DIP, FIFO_DI}), 64'({m_dip, m_di}));
      check_val("rden",     64'(FIFO_RDEN), 64'(exp_rden));
      check_val("rd_valid", 64'(RD_VALID),  64'(m_rdv));
      check_val("err",      64'(ERR),       64'(m_err));

      @(posedge CLK);
      #1;
      m_rdv  = exp_rden;
      m_err  = (CLR_ERR ? 2'b00 : m_err) | {FIFO_RDERR, FIFO_WRERR};
      m_pend = (g >= 0);
      if (g >= 0) begin
        m_di  = word[g];
        m_dip = par[g];
`ifdef FIFO16_SHARE_PRIO0_EN
        if (g != 0) ptr = (g + 1) % NREQ;
`else
        ptr = (g + 1) % NREQ;
`endif
      end
      age = SOFT_RST ? 0 : ((age < 1000) ? age + 1 : age);
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !rq[i]) begin
          rq[i]   = new_req(mode, i);
          word[i] = $urandom;
          par[i]  = 4'($urandom);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      rq[i] = 1'b1; word[i] = $urandom; par[i] = 4'($urandom);
    end
    model_reset();
    @(posedge CLK);
    async_reset();
    for (int p = 0; p < 14; p++) begin
      if (p == 7) async_reset();
      run_cycles(p % 7 == 6 ? 5 : p % 7, 50);
    end
    SOFT_RST = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo16_share_ctrl.md
Name: fifo16_share_ctrl

Overview:
Single-clock controller that owns one 36-bit FIFO16 instance used in synchronous mode, with RDCLK and WRCLK tied to CLK.
- Sequences the FIFO reset.
- Arbitrates write access round-robin among NREQ requesters.
- Throttles writes near full.
- Issues reads for one consumer.
- Records FIFO error flags in sticky bits.

Parameters:
NREQ, 4, number of write requesters (2..8)
RST_HOLD, 5, cycles FIFO_RST is held high (minimum 3)
RST_WAIT, 4, idle cycles after FIFO_RST falls before READY

Ports:
CLK  in  1  single clock for controller and FIFO
RST_N  in  1  asynchronous active-low reset
SOFT_RST  in  1  one-cycle pulse; restarts the reset sequence
REQ  in  NREQ  write request per requester; held until granted
REQ_DI  in  NREQ*32  data, requester i at [32i+31:32i]
REQ_DIP  in  NREQ*4  parity, requester i at [4i+3:4i]
GNT  out  NREQ  one-hot; data of granted requester captured this cycle
RD_REQ  in  1  consumer pop request
RD_VALID  out  1  FIFO_DO/DOP valid this cycle
READY  out  1  controller in RUN state
ERR  out  2  sticky {rderr, wrerr}
CLR_ERR  in  1  clears ERR
FIFO_RST  out  1  to FIFO RST
FIFO_WREN  out  1  to FIFO WREN
FIFO_DI  out  32  to FIFO DI
FIFO_DIP  out  4  to FIFO DIP
FIFO_RDEN  out  1  to FIFO RDEN
FIFO_FULL, FIFO_ALMOSTFULL, FIFO_EMPTY, FIFO_WRERR, FIFO_RDERR  in  1 each  from FIFO

Behaviour:
Reset values when RST_N=0 (immediate):
- state=HOLD, FIFO_RST=1.
- GNT, FIFO_WREN, FIFO_RDEN, RD_VALID, READY = 0.
- ERR=0, FIFO_DI/DIP=0.
- Round-robin pointer = 0.

State machine:
- HOLD: FIFO_RST=1 for RST_HOLD cycles → WAIT.
- WAIT: FIFO_RST=0; no WREN/RDEN for RST_WAIT cycles → RUN.
- RUN: READY=1.
- SOFT_RST in any state → HOLD next cycle. Any captured-but-unissued write is dropped. FIFO_WREN and FIFO_RDEN are 0 from that cycle onward.
- GNT, WREN and RDEN are never asserted outside RUN.

Write arbitration (RUN only):
- Eligible: REQ[i]=1 and write gate open.
- Gate open when FIFO_ALMOSTFULL=0, or when FIFO_ALMOSTFULL=1 and FIFO_FULL=0 and no write was issued in the previous cycle. Near full, this limits writes to one every 2 cycles.
- Grant goes to the first eligible requester at or after pointer. Pointer then moves to granted+1, modulo NREQ.
- GNT is combinational in cycle C. Data is registered at the end of C. FIFO_WREN=1 with that data in cycle C+1 (1-cycle latency).
- At most one grant per cycle. Requester drops REQ or presents next word after GNT.

Read:
- FIFO_RDEN = RUN & RD_REQ & ~FIFO_EMPTY (combinational).
- RD_VALID = FIFO_RDEN registered, aligned with FIFO DO.

Errors:
- ERR[0] set on FIFO_WRERR, ERR[1] set on FIFO_RDERR.
- CLR_ERR clears. If set and clear occur together, set wins.
- ERR is not cleared by SOFT_RST.

Boundaries:
- FULL=1: no grants.
- EMPTY=1: RDEN=0 even if RD_REQ=1.
- Simultaneous write and read are allowed.
- Pointer wraps NREQ-1 → 0.
- RST_N deassertion mid-stream always restarts from HOLD.

Optional Feature:
FIFO16_SHARE_PRIO0_EN:
- Defined: requester 0 has strict priority. It is granted whenever eligible, regardless of pointer. The pointer is not updated on a requester-0 grant; round-robin applies among 1..NREQ-1.
- Undefined: plain round-robin over all requesters.

Test Plan:
1. Release RST_N → FIFO_RST high cycles 0-4, low cycles 5-8, READY=1 at cycle 9. No WREN/RDEN before cycle 9.
2. All 4 REQ held, FULL=0, ALMOSTFULL=0 → GNT sequence 0001,0010,0100,1000,0001. FIFO_WREN continuous, each word one cycle after its GNT.
3. ALMOSTFULL=1, FULL=0, REQ[2] held → GNT every other cycle. FULL=1 → no GNT until FULL=0.
4. RD_REQ=1 with EMPTY=0 for 3 cycles, then EMPTY=1 → 3 RDEN pulses, RD_VALID 3 cycles delayed by 1, RDEN=0 while EMPTY=1.
5. SOFT_RST one cycle after GNT to requester 1 → no FIFO_WREN for that word. FIFO_RST high next 5 cycles. READY drops, then rises after 9 cycles.
6. FIFO_WRERR pulse → ERR=01 holds. CLR_ERR with RDERR in the same cycle → ERR=10.
